// File: rtl/writeback_stage_pkg.sv
// Shared constants for the writeback stage: datapath widths, control-bundle
// bit positions (same map as decode / control unit), result-select encoding.
package writeback_stage_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int CTRL_W = 11;
  localparam int CNT_W  = 16;

  localparam int CTRL_MTR       = 4;
  localparam int CTRL_REG_WRITE = 6;
  localparam int CTRL_IN        = 7;
  localparam int CTRL_OUT       = 8;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'd0,
    WB_SEL_MEM = 2'd1,
    WB_SEL_IN  = 2'd2
  } wb_sel_e;

  // In outranks MTR; anything else retires the ALU result.
  function automatic wb_sel_e wb_select(input logic i_in, input logic i_mtr);
    if (i_in)
      return WB_SEL_IN;
    else if (i_mtr)
      return WB_SEL_MEM;
    else
      return WB_SEL_ALU;
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// MEM/WB boundary bundle: memory stage drives (master), writeback consumes (slave).
interface writeback_stage_if #(
  parameter int DATA_W = writeback_stage_pkg::DATA_W,
  parameter int ADDR_W = writeback_stage_pkg::ADDR_W,
  parameter int CTRL_W = writeback_stage_pkg::CTRL_W
);

  logic              mw_valid;
  logic [CTRL_W-1:0] mw_ctrl;
  logic [ADDR_W-1:0] mw_rdst;
  logic [DATA_W-1:0] mw_alu_result;
  logic [DATA_W-1:0] mw_mem_data;
  logic [DATA_W-1:0] mw_src_data;

  modport master (
    output mw_valid, mw_ctrl, mw_rdst, mw_alu_result, mw_mem_data, mw_src_data
  );

  modport slave (
    input mw_valid, mw_ctrl, mw_rdst, mw_alu_result, mw_mem_data, mw_src_data
  );

endinterface

// File: rtl/writeback_stage_wb_result_mux.sv
// Combinational writeback data select: input-port sample, load data or ALU result.
module wb_result_mux
  import writeback_stage_pkg::*;
#(
  parameter int DATA_W = writeback_stage_pkg::DATA_W
) (
  input  logic              i_in,
  input  logic              i_mtr,
  input  logic [DATA_W-1:0] i_alu,
  input  logic [DATA_W-1:0] i_mem,
  input  logic [DATA_W-1:0] i_in_sample,
  output logic [DATA_W-1:0] o_data
);

  wb_sel_e w_sel;

  assign w_sel = wb_select(i_in, i_mtr);

  // Route the selected source to the register-file write data.
  always_comb begin
    o_data = '0;
    case (w_sel)
      WB_SEL_IN:  o_data = i_in_sample;
      WB_SEL_MEM: o_data = i_mem;
      WB_SEL_ALU: o_data = i_alu;
      default:    o_data = i_alu;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: MEM/WB register, register-file write port with a
// forwarding mirror, registered OUT port and retired-instruction counter.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DATA_W = writeback_stage_pkg::DATA_W,
  parameter int ADDR_W = writeback_stage_pkg::ADDR_W,
  parameter int CTRL_W = writeback_stage_pkg::CTRL_W,
  parameter int CNT_W  = writeback_stage_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  writeback_stage_if.slave   mw,
  input  logic [DATA_W-1:0]  in_port,
  input  logic               stall,
  input  logic               flush,
  output logic [ADDR_W-1:0]  WriteAddress,
  output logic               WriteEnable,
  output logic [DATA_W-1:0]  WriteData,
  output logic               fwd_valid,
  output logic [ADDR_W-1:0]  fwd_addr,
  output logic [DATA_W-1:0]  fwd_data,
  output logic [DATA_W-1:0]  out_port,
  output logic               out_strobe,
  output logic [CNT_W-1:0]   retire_count
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [ADDR_W-1:0] r_rdst;
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_mem;
  logic [DATA_W-1:0] r_in;
  logic [DATA_W-1:0] r_src;

  logic [DATA_W-1:0] r_out;
  logic              r_strobe;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_retire;
  logic              w_we;
  logic [DATA_W-1:0] w_wdata;
  logic              w_unused_ctrl;

  // MEM/WB register: reset > flush > stall > load; in_port sampled at load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_rdst  <= '0;
      r_alu   <= '0;
      r_mem   <= '0;
      r_in    <= '0;
      r_src   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (!stall) begin
      r_valid <= mw.mw_valid;
      r_ctrl  <= mw.mw_ctrl;
      r_rdst  <= mw.mw_rdst;
      r_alu   <= mw.mw_alu_result;
      r_mem   <= mw.mw_mem_data;
      r_in    <= in_port;
      r_src   <= mw.mw_src_data;
    end
  end

  // A held instruction keeps writing, but retires only on the edge it leaves WB.
  assign w_retire = r_valid & ~stall;

  // Retire side effects: counter, OUT port update and its one-cycle strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out    <= '0;
      r_strobe <= 1'b0;
      r_cnt    <= '0;
    end else if (w_retire) begin
      r_cnt    <= r_cnt + CNT_W'(1);
      r_strobe <= r_ctrl[CTRL_OUT];
      if (r_ctrl[CTRL_OUT])
        r_out <= r_src;
    end else begin
      r_strobe <= 1'b0;
    end
  end

  wb_result_mux #(
    .DATA_W (DATA_W)
  ) u_result_mux (
    .i_in        (r_ctrl[CTRL_IN]),
    .i_mtr       (r_ctrl[CTRL_MTR]),
    .i_alu       (r_alu),
    .i_mem       (r_mem),
    .i_in_sample (r_in),
    .o_data      (w_wdata)
  );

  assign w_we = r_valid & r_ctrl[CTRL_REG_WRITE];

  // Only a handful of control bits matter in this stage.
  assign w_unused_ctrl = ^r_ctrl;

  assign WriteEnable  = w_we;
  assign WriteAddress = r_rdst;
  assign WriteData    = w_wdata;

  assign fwd_valid = w_we;
  assign fwd_addr  = r_rdst;
  assign fwd_data  = w_wdata;

  assign out_port     = r_out;
  assign out_strobe   = r_strobe;
  assign retire_count = r_cnt;

endmodule
